// File: rtl/spi_target_regif.sv
// -----------------------------------------------------------------------------
// spi_target_regif
//
// SPI mode-0 target that gives an external host read/write access to a simple
// register bus. SCLK, CS_N and MOSI are oversampled in the fabric clock domain.
// Each frame is a command byte followed by a burst of data bytes:
//   command bit 7 = 1 : read,  bits [6:0] = start address
//   command bit 7 = 0 : write, bits [6:0] = start address
// The address increments after every data byte and wraps modulo 2^ADDR_W.
//
// Ports:
//   clk          fabric clock (SPI PLL output)
//   rst_n        synchronous active-low reset
//   pll_lock     PLL lock; low acts exactly like rst_n low
//   spi_sclk     host serial clock (asynchronous)
//   spi_cs_n     host chip select, active low (asynchronous)
//   spi_mosi     host data out (asynchronous)
//   spi_miso     target data out
//   spi_miso_oe  MISO pad output enable
//   reg_wr_en    one-cycle register write strobe
//   reg_rd_en    one-cycle register read strobe
//   reg_addr     register address, held until the next strobe
//   reg_wdata    register write data, held until the next write strobe
//   reg_rdata    register read data, captured one clk after reg_rd_en
//   frame_err    one-cycle pulse when CS_N rises in the middle of a byte
// -----------------------------------------------------------------------------
module spi_target_regif #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pll_lock,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              reg_wr_en,
  output logic              reg_rd_en,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              frame_err
);

  localparam int BIT_W    = $clog2(DATA_W);
  localparam int WARM_MAX = SYNC_STAGES + 1;
  localparam int WARM_W   = $clog2(WARM_MAX + 1);
  localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_W - 1);
  localparam logic [WARM_W-1:0] WARM_END = WARM_W'(WARM_MAX);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } state_t;

  logic                   in_reset;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_hist;
  logic                   cs_hist;
  logic [WARM_W-1:0]      warm;
  logic                   ready;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   cs_fall;
  logic                   cs_rise;

  state_t                 state;
  logic [BIT_W-1:0]       bit_cnt;
  logic [DATA_W-2:0]      shift_in;
  logic [DATA_W-1:0]      byte_next;
  logic [DATA_W-1:0]      tx;
  logic [ADDR_W-1:0]      addr;
  logic                   is_read;

  assign in_reset = !rst_n || !pll_lock;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // The synchronisers restart from idle levels after reset, so the first few
  // cycles could show a phantom edge (e.g. CS_N still low from an interrupted
  // frame). Edge events are suppressed until the history flop has caught up
  // with the real pin level, which forces a genuinely fresh cs_fall.
  assign ready     = (warm == WARM_END);
  assign sclk_rise = ready &&  sclk_s && !sclk_hist;
  assign sclk_fall = ready && !sclk_s &&  sclk_hist;
  assign cs_fall   = ready && !cs_s   &&  cs_hist;
  assign cs_rise   = ready &&  cs_s   && !cs_hist;

  // Byte as it stands once the current MOSI sample is shifted in (MSB first).
  assign byte_next = {shift_in, mosi_s};

  assign spi_miso_oe = (state != IDLE);
  assign spi_miso    = (state == DATA) && is_read && tx[DATA_W-1];

  // Input synchronisers, edge history and post-reset warm-up counter.
  always_ff @(posedge clk) begin
    if (in_reset) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_hist <= 1'b0;
      cs_hist   <= 1'b1;
      warm      <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      sclk_hist <= sclk_s;
      cs_hist   <= cs_s;
      if (!ready) begin
        warm <= warm + WARM_W'(1);
      end
    end
  end

  // Frame FSM with registered register-bus strobes.
  always_ff @(posedge clk) begin
    if (in_reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_in  <= '0;
      tx        <= '0;
      addr      <= '0;
      is_read   <= 1'b0;
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      frame_err <= 1'b0;
    end else begin
      reg_wr_en <= 1'b0;
      reg_rd_en <= 1'b0;
      frame_err <= 1'b0;

      // Read data arrives one clk after the read strobe; it becomes the next
      // byte to serialise. Bytes are far longer than this, so it never
      // collides with a falling-edge shift.
      if (reg_rd_en) begin
        tx <= reg_rdata;
      end

      case (state)
        IDLE: begin
          if (cs_fall) begin
            state    <= CMD;
            bit_cnt  <= '0;
            shift_in <= '0;
            is_read  <= 1'b0;
          end
        end

        CMD, DATA: begin
          if (cs_rise) begin
            // A partial byte is dropped silently apart from the error pulse.
            frame_err <= (bit_cnt != '0);
            state     <= IDLE;
            bit_cnt   <= '0;
          end else if (sclk_rise) begin
            bit_cnt  <= bit_cnt + BIT_W'(1);
            shift_in <= byte_next[DATA_W-2:0];
            if (bit_cnt == LAST_BIT) begin
              if (state == CMD) begin
                state   <= DATA;
                is_read <= byte_next[DATA_W-1];
                addr    <= byte_next[ADDR_W-1:0];
                if (byte_next[DATA_W-1]) begin
                  reg_rd_en <= 1'b1;
                  reg_addr  <= byte_next[ADDR_W-1:0];
                end
              end else if (is_read) begin
                // Prefetch the following address so its data is ready
                // before the next byte starts shifting out.
                addr      <= addr + ADDR_W'(1);
                reg_rd_en <= 1'b1;
                reg_addr  <= addr + ADDR_W'(1);
              end else begin
                reg_wr_en <= 1'b1;
                reg_addr  <= addr;
                reg_wdata <= byte_next;
                addr      <= addr + ADDR_W'(1);
              end
            end
          end else if (sclk_fall && (state == DATA) && is_read &&
                       (bit_cnt != '0) && !reg_rd_en) begin
            // The fall right after a byte boundary must not shift: the MSB of
            // the freshly loaded byte has to be on MISO for the first rise.
            tx <= {tx[DATA_W-2:0], 1'b0};
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_target_regif.sv
// -----------------------------------------------------------------------------
// tb_spi_target_regif
//
// Drives SPI frames into spi_target_regif and compares the register-bus
// strobes, MISO bytes and frame errors against a frame-level reference model.
// The register file behind the bus is a plain array read combinationally.
// -----------------------------------------------------------------------------
module tb_spi_target_regif;

  localparam int ADDR_W      = 7;
  localparam int DATA_W      = 8;
  localparam int SYNC_STAGES = 2;
  localparam int MIN_HALF    = SYNC_STAGES + 4;
  localparam int MIN_CS_HIGH = SYNC_STAGES + 2;

  logic              clk;
  logic              rst_n;
  logic              pll_lock;
  logic              spi_sclk;
  logic              spi_cs_n;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic              reg_wr_en;
  logic              reg_rd_en;
  logic [ADDR_W-1:0] reg_addr;
  logic [DATA_W-1:0] reg_wdata;
  logic [DATA_W-1:0] reg_rdata;
  logic              frame_err;

  logic [7:0] mem [128];

  assign reg_rdata = mem[reg_addr];

  spi_target_regif #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_lock    (pll_lock),
    .spi_sclk    (spi_sclk),
    .spi_cs_n    (spi_cs_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .reg_wr_en   (reg_wr_en),
    .reg_rd_en   (reg_rd_en),
    .reg_addr    (reg_addr),
    .reg_wdata   (reg_wdata),
    .reg_rdata   (reg_rdata),
    .frame_err   (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One frame: b[0] is the command, then data bytes; nbytes counts complete
  // bytes and partial is the number of extra bits of b[nbytes] before CS_N rises.
  typedef struct {
    logic [4:0][7:0] b;
    int nbytes;
    int partial;
    int half;
    int cs_high;
    int n_wr;
    int n_rd;
    int ferr;
  } vec_t;

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] data;
  } wr_t;

  int assert_count = 0;
  int fail_count   = 0;

  logic capture_on = 1'b0;
  wr_t        wr_q[$];
  logic [6:0] rd_q[$];
  logic [7:0] miso_q[$];
  int ferr_seen;
  int strobe_bad;
  int oe_bad;
  logic prev_wr = 1'b0;
  logic prev_rd = 1'b0;

  wr_t        exp_wr[$];
  logic [6:0] exp_rd[$];
  logic [7:0] exp_miso[$];

  vec_t table_v[8];

  // Bus monitor: records every strobe and flags overlapping or stretched ones.
  always @(negedge clk) begin
    if (capture_on) begin
      if (reg_wr_en) wr_q.push_back({reg_addr, reg_wdata});
      if (reg_rd_en) rd_q.push_back(reg_addr);
      if (frame_err) ferr_seen++;
      if (reg_wr_en && reg_rd_en) strobe_bad++;
      if ((reg_wr_en && prev_wr) || (reg_rd_en && prev_rd)) strobe_bad++;
    end
    prev_wr = reg_wr_en;
    prev_rd = reg_rd_en;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic vec_t make_vec(input int nbytes, input int partial, input int n_wr,
                                    input int n_rd, input int ferr,
                                    input logic [7:0] b0, input logic [7:0] b1,
                                    input logic [7:0] b2, input logic [7:0] b3,
                                    input logic [7:0] b4);
    vec_t v;
    v.b       = {b4, b3, b2, b1, b0};
    v.nbytes  = nbytes;
    v.partial = partial;
    v.half    = MIN_HALF;
    v.cs_high = MIN_CS_HIGH;
    v.n_wr    = n_wr;
    v.n_rd    = n_rd;
    v.ferr    = ferr;
    return v;
  endfunction

  // Frame-level reference: what the host should observe for a whole frame.
  task automatic model(input vec_t v);
    logic [7:0] cmd;
    int base;
    exp_wr.delete();
    exp_rd.delete();
    exp_miso.delete();
    cmd  = v.b[0];
    base = int'(cmd[6:0]);
    if (cmd[7]) begin
      exp_rd.push_back(7'(base));
      for (int i = 1; i < v.nbytes; i++) begin
        exp_miso.push_back(mem[(base + i - 1) % 128]);
        exp_rd.push_back(7'((base + i) % 128));
      end
    end else begin
      for (int i = 1; i < v.nbytes; i++) begin
        exp_wr.push_back({7'((base + i - 1) % 128), v.b[i]});
      end
    end
  endtask

  task automatic clear_capture();
    wr_q.delete();
    rd_q.delete();
    miso_q.delete();
    ferr_seen  = 0;
    strobe_bad = 0;
    oe_bad     = 0;
  endtask

  // Mode 0: MOSI set while SCLK is low, both sides sample on the rise.
  task automatic send_bits(input logic [7:0] val, input int nbits, input int half,
                           output logic [7:0] rx);
    rx = '0;
    for (int k = 0; k < nbits; k++) begin
      spi_mosi = val[7-k];
      repeat (half) @(negedge clk);
      rx = {rx[6:0], spi_miso};
      if (!spi_miso_oe) oe_bad++;
      spi_sclk = 1'b1;
      repeat (half) @(negedge clk);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [7:0] rx;
    clear_capture();
    capture_on = 1'b1;
    spi_cs_n = 1'b0;
    repeat (v.half) @(negedge clk);
    for (int i = 0; i < v.nbytes; i++) begin
      send_bits(v.b[i], 8, v.half, rx);
      if (i >= 1) miso_q.push_back(rx);
    end
    if (v.partial > 0) send_bits(v.b[v.nbytes], v.partial, v.half, rx);
    repeat (v.half) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (v.cs_high) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input vec_t v);
    checkOutput({tag, ".wr_count"}, wr_q.size(), v.n_wr);
    for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++) begin
      checkOutput({tag, ".wr_addr"}, int'(wr_q[i].addr), int'(exp_wr[i].addr));
      checkOutput({tag, ".wr_data"}, int'(wr_q[i].data), int'(exp_wr[i].data));
    end
    checkOutput({tag, ".rd_count"}, rd_q.size(), v.n_rd);
    for (int i = 0; i < rd_q.size() && i < exp_rd.size(); i++) begin
      checkOutput({tag, ".rd_addr"}, int'(rd_q[i]), int'(exp_rd[i]));
    end
    for (int i = 0; i < miso_q.size() && i < exp_miso.size(); i++) begin
      checkOutput({tag, ".miso_byte"}, int'(miso_q[i]), int'(exp_miso[i]));
    end
    checkOutput({tag, ".frame_err"}, ferr_seen, v.ferr);
    checkOutput({tag, ".strobe_shape"}, strobe_bad, 0);
    checkOutput({tag, ".oe_in_frame"}, oe_bad, 0);
    checkOutput({tag, ".oe_idle"}, int'(spi_miso_oe), 0);
    checkOutput({tag, ".miso_idle"}, int'(spi_miso), 0);
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, ".wr_en"}, int'(reg_wr_en), 0);
    checkOutput({tag, ".rd_en"}, int'(reg_rd_en), 0);
    checkOutput({tag, ".addr"}, int'(reg_addr), 0);
    checkOutput({tag, ".wdata"}, int'(reg_wdata), 0);
    checkOutput({tag, ".frame_err"}, int'(frame_err), 0);
    checkOutput({tag, ".miso"}, int'(spi_miso), 0);
    checkOutput({tag, ".oe"}, int'(spi_miso_oe), 0);
  endtask

  initial begin
    vec_t v;
    logic [7:0] rx;

    for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
    mem[8'h22] = 8'h3C;

    // cnt, part, wr, rd, ferr, bytes
    table_v[0] = make_vec(2, 0, 1, 0, 0, 8'h15, 8'hA5, 8'h00, 8'h00, 8'h00);
    table_v[1] = make_vec(2, 0, 0, 2, 0, 8'hA2, 8'h00, 8'h00, 8'h00, 8'h00);
    table_v[2] = make_vec(4, 0, 3, 0, 0, 8'h7E, 8'h01, 8'h02, 8'h03, 8'h00);
    table_v[3] = make_vec(1, 5, 0, 0, 1, 8'h10, 8'hE7, 8'h00, 8'h00, 8'h00);
    table_v[4] = make_vec(2, 0, 1, 0, 0, 8'h10, 8'h55, 8'h00, 8'h00, 8'h00);
    table_v[5] = make_vec(1, 0, 0, 0, 0, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00);
    table_v[6] = make_vec(3, 0, 0, 3, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
    table_v[7] = make_vec(2, 3, 1, 0, 1, 8'h40, 8'hC3, 8'hA0, 8'h00, 8'h00);

    rst_n    = 1'b0;
    pll_lock = 1'b1;
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Back-to-back frames at minimum SCLK half-period and CS_N high time.
    for (int i = 0; i < 8; i++) begin
      model(table_v[i]);
      applyStimulus(table_v[i]);
      check_frame($sformatf("vec%0d", i), table_v[i]);
    end

    // Lock drops mid-data-byte with CS_N still low: the rest of the frame
    // must be ignored until a fresh CS_N fall.
    clear_capture();
    capture_on = 1'b1;
    spi_cs_n = 1'b0;
    repeat (MIN_HALF) @(negedge clk);
    send_bits(8'h20, 8, MIN_HALF, rx);
    send_bits(8'h77, 3, MIN_HALF, rx);
    pll_lock = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("pll_drop");
    pll_lock = 1'b1;
    send_bits(8'hE0, 5, MIN_HALF, rx);
    send_bits(8'h99, 8, MIN_HALF, rx);
    repeat (MIN_HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (MIN_CS_HIGH + 2) @(negedge clk);
    checkOutput("pll_drop.wr_count", wr_q.size(), 0);
    checkOutput("pll_drop.rd_count", rd_q.size(), 0);
    checkOutput("pll_drop.frame_err", ferr_seen, 0);
    v = make_vec(2, 0, 1, 0, 0, 8'h20, 8'h66, 8'h00, 8'h00, 8'h00);
    model(v);
    applyStimulus(v);
    check_frame("pll_after", v);

    // Randomised frames against the reference model.
    for (int n = 0; n < 12; n++) begin
      v.b       = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
      v.nbytes  = int'($urandom_range(1, 4));
      v.partial = int'($urandom_range(0, 7));
      v.half    = int'($urandom_range(MIN_HALF, MIN_HALF + 3));
      v.cs_high = int'($urandom_range(MIN_CS_HIGH, MIN_CS_HIGH + 4));
      model(v);
      v.n_wr = exp_wr.size();
      v.n_rd = exp_rd.size();
      v.ferr = (v.partial != 0) ? 1 : 0;
      applyStimulus(v);
      check_frame($sformatf("rand%0d", n), v);
    end

    capture_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
